probe_pattern_gen: RTL and testbench

PROBE_PATTERN_GEN -- requirements
Module: probe_pattern_gen

---
 rtl/probe_pattern_gen.sv | 142 ++++++++++++++
 tb/tb_probe_pattern_gen.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/probe_pattern_gen.sv
// Multi-channel probe pattern generator: per-channel up/down/LFSR/walking-one
// sequences stepped every rate+1 cycles, for a fixed burst or until stopped.
module probe_pattern_gen #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 16,
  parameter int LEN_W  = 16,
  parameter int RATE_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_we,
  input  logic [2:0]              cfg_ch,
  input  logic [1:0]              cfg_mode,
  input  logic [WIDTH-1:0]        cfg_seed,
  input  logic [RATE_W-1:0]       rate,
  input  logic [LEN_W-1:0]        burst_len,
  input  logic                    start,
  input  logic                    stop,
  output logic [NUM_CH*WIDTH-1:0] probe_data,
  output logic                    probe_valid,
  output logic                    busy,
  output logic                    done,
  output logic [1:0]              dbg_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  localparam int              TAP      = (WIDTH > 1) ? WIDTH - 2 : 0;
  localparam logic [3:0]      NUM_CH_L = 4'(NUM_CH);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  state_t              r_state, w_next;
  logic                r_rst_q;
  logic                w_rst_n;
  logic [RATE_W-1:0]   r_rate, r_div;
  logic [LEN_W-1:0]    r_len, r_cnt;
  logic                r_fin, r_valid;
  logic [1:0]          r_mode [NUM_CH];
  logic [WIDTH-1:0]    r_seed [NUM_CH];
  logic [WIDTH-1:0]    r_val  [NUM_CH];
  logic                w_step, w_last, w_start, w_cfg_ok;

  function automatic logic [WIDTH-1:0] f_next(input logic [1:0] m, input logic [WIDTH-1:0] v);
    case (m)
      2'd0:    f_next = v + ONE;
      2'd1:    f_next = v - ONE;
      2'd2:    f_next = (v << 1) | WIDTH'(v[WIDTH-1] ^ v[TAP]);
      default: f_next = (v << 1) | (v >> (WIDTH - 1));
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] f_load(input logic [1:0] m, input logic [WIDTH-1:0] s);
    f_load = (m[1] && (s == '0)) ? ONE : s;
  endfunction

  // Assertion is immediate; release is retimed so the first start lands on the 2nd edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rst_q <= 1'b0;
    else      r_rst_q <= 1'b1;
  end
  assign w_rst_n = r_rst_q;

  // start/stop are single-cycle requests with no ready; probe_valid is a
  // one-cycle strobe with no backpressure, qualifying probe_data that cycle.
  assign w_start  = (r_state == S_IDLE) && start && !stop;
  assign w_step   = (r_state == S_RUN) && !r_fin && (r_div == r_rate);
  assign w_last   = w_step && (r_len != '0) && (r_cnt == r_len - LEN_W'(1));
  assign w_cfg_ok = (r_state == S_IDLE) && cfg_we && ({1'b0, cfg_ch} < NUM_CH_L);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = S_RUN;
      S_RUN: begin
        // A step that finishes the run still gets its probe_valid cycle first.
        if (r_fin)                w_next = S_DONE;
        else if (stop && !w_step) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_rate  <= '0;
      r_len   <= '0;
      r_div   <= '0;
      r_cnt   <= '0;
      r_fin   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_valid <= w_step;
      if (w_start) begin
        r_rate <= rate;
        r_len  <= burst_len;
        r_div  <= '0;
        r_cnt  <= '0;
        r_fin  <= 1'b0;
      end else if ((r_state == S_RUN) && !r_fin) begin
        if (w_step) begin
          r_div <= '0;
          r_cnt <= r_cnt + LEN_W'(1);
          if (w_last || stop) r_fin <= 1'b1;
        end else begin
          r_div <= r_div + RATE_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_mode[i] <= 2'd0;
        r_seed[i] <= '0;
        r_val[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_cfg_ok && (cfg_ch == 3'(i))) begin
          r_mode[i] <= cfg_mode;
          r_seed[i] <= cfg_seed;
        end
        if (w_start)     r_val[i] <= f_load(r_mode[i], r_seed[i]);
        else if (w_step) r_val[i] <= f_next(r_mode[i], r_val[i]);
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign probe_data[g*WIDTH +: WIDTH] = r_val[g];
  end

  assign probe_valid = r_valid;
  assign busy        = (r_state == S_RUN);
  assign done        = (r_state == S_DONE);
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_probe_pattern_gen.sv
// Bench for probe_pattern_gen: a 16-bit and a 4-bit instance share one stimulus
// bus; a behavioural channel model feeds expected-data queues for both.
module tb_probe_pattern_gen;

  localparam int NCH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_ch = '0;
  logic [1:0]  cfg_mode = '0;
  logic [15:0] cfg_seed = '0;
  logic [7:0]  rate = '0;
  logic [15:0] burst_len = '0;
  logic        start = 1'b0, stop = 1'b0;

  logic [63:0] probe_data;
  logic        probe_valid, busy, done;
  logic [1:0]  dbg_state;
  logic [15:0] probe_data4;
  logic        probe_valid4, busy4, done4;
  logic [1:0]  dbg_state4;

  always #5 clk = ~clk;

  probe_pattern_gen dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_seed(cfg_seed), .rate(rate), .burst_len(burst_len), .start(start), .stop(stop),
    .probe_data(probe_data), .probe_valid(probe_valid), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  probe_pattern_gen #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_seed(cfg_seed[3:0]), .rate(rate), .burst_len(burst_len), .start(start), .stop(stop),
    .probe_data(probe_data4), .probe_valid(probe_valid4), .busy(busy4), .done(done4),
    .dbg_state(dbg_state4)
  );

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  logic [15:0] exp4_q[$];
  int n_checks = 0, n_errors = 0;
  int done_seen = 0, done_exp = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (probe_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL spurious_valid: got data %h expected no strobe", probe_data);
      end else chk("probe_data", probe_data, exp_q.pop_front());
    end
    if (probe_valid4) begin
      if (exp4_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL spurious_valid4: got data %h expected no strobe", probe_data4);
      end else chk("probe_data4", probe_data4, exp4_q.pop_front());
    end
    if (done) done_seen++;
  end

  // ---------------- behavioural model ----------------
  logic [1:0]  m_mode [NCH];
  logic [15:0] m_seed [NCH];
  logic [31:0] m_cur  [NCH];
  logic [31:0] m_cur4 [NCH];

  function automatic logic [31:0] mstep(input logic [1:0] md, input logic [31:0] v, input int w);
    logic [31:0] mask, fb;
    mask = (32'h1 << w) - 32'h1;
    case (md)
      2'd0: return (v + 32'h1) & mask;
      2'd1: return (v + mask) & mask;
      2'd2: begin
        fb = ((v >> (w - 1)) ^ (v >> (w - 2))) & 32'h1;
        return ((v << 1) | fb) & mask;
      end
      default: return ((v << 1) | (v >> (w - 1))) & mask;
    endcase
  endfunction

  function automatic logic [31:0] mload(input logic [1:0] md, input logic [15:0] sd, input int w);
    logic [31:0] s;
    s = {16'h0, sd} & ((32'h1 << w) - 32'h1);
    return (md >= 2'd2 && s == 0) ? 32'h1 : s;
  endfunction

  function automatic logic [63:0] pack16();
    logic [63:0] p;
    p = '0;
    for (int i = 0; i < NCH; i++) p[i*16 +: 16] = m_cur[i][15:0];
    return p;
  endfunction

  function automatic logic [15:0] pack4();
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < NCH; i++) p[i*4 +: 4] = m_cur4[i][3:0];
    return p;
  endfunction

  task automatic model_run(input int steps, output logic [63:0] lp16, output logic [15:0] lp4);
    for (int i = 0; i < NCH; i++) begin
      m_cur[i]  = mload(m_mode[i], m_seed[i], 16);
      m_cur4[i] = mload(m_mode[i], m_seed[i], 4);
    end
    lp16 = pack16();
    lp4  = pack4();
    for (int j = 0; j < steps; j++) begin
      for (int i = 0; i < NCH; i++) begin
        m_cur[i]  = mstep(m_mode[i], m_cur[i], 16);
        m_cur4[i] = mstep(m_mode[i], m_cur4[i], 4);
      end
      exp_q.push_back(pack16());
      exp4_q.push_back(pack4());
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_mode[i] = 2'd0; m_seed[i] = '0; m_cur[i] = '0; m_cur4[i] = '0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cfg_write(input int ch, input logic [1:0] md, input logic [15:0] sd);
    @(negedge clk);
    cfg_we = 1'b1; cfg_ch = ch[2:0]; cfg_mode = md; cfg_seed = sd;
    @(negedge clk);
    cfg_we = 1'b0;
    if (ch < NCH) begin m_mode[ch] = md; m_seed[ch] = sd; end
  endtask

  // One run; restart_at/stop_at/poke_at are cycle indices after the start edge (-1 = none).
  task automatic do_run(input int r, input int n, input int restart_at, input int stop_at,
                        input int poke_at);
    int s, k, steps, done_idx, first_done, ndone;
    logic [63:0] lp16;
    logic [15:0] lp4;
    logic exp_v;
    if (stop_at < 0) begin
      steps = n; done_idx = (r + 1) * n + 1;
    end else begin
      s = stop_at + 1; k = s / (r + 1);
      if (n > 0 && k >= n) begin
        steps = n; done_idx = (r + 1) * n + 1;
      end else begin
        steps = k; done_idx = (s % (r + 1) == 0) ? s + 1 : s;
      end
    end
    model_run(steps, lp16, lp4);
    @(negedge clk);
    rate = r[7:0]; burst_len = n[15:0]; start = 1'b1;
    done_exp++;
    ndone = 0; first_done = -1;
    for (int idx = 0; idx <= done_idx + 2; idx++) begin
      @(negedge clk);
      start  = (idx == restart_at);
      stop   = (idx == stop_at);
      cfg_we = (idx == poke_at);
      if (idx == poke_at) begin cfg_ch = 3'd0; cfg_mode = 2'd3; cfg_seed = 16'hDEAD; end
      if (idx == 0) begin
        chk("busy_in_run", busy, 1'b1);
        chk("load_data", probe_data, lp16);
        chk("load_data4", probe_data4, lp4);
      end
      exp_v = (idx > 0) && (idx % (r + 1) == 0) && (idx / (r + 1) <= steps);
      chk("valid_timing", probe_valid, exp_v);
      if (done) begin
        ndone++;
        if (first_done < 0) first_done = idx;
      end
    end
    start = 1'b0; stop = 1'b0; cfg_we = 1'b0;
    chk("done_cycle", first_done, done_idx);
    chk("done_once", ndone, 1);
    chk("busy_after", busy, 1'b0);
    chk("data_frozen", probe_data, pack16());
    chk("data4_frozen", probe_data4, pack4());
    chk("q_drained", exp_q.size(), 0);
    chk("q4_drained", exp4_q.size(), 0);
  endtask

  // ---------------- test ----------------
  typedef struct {
    logic [1:0]  mode;
    logic [15:0] seed;
    int          r;
    int          n;
    logic [15:0] exp_last;
  } vec_t;
  vec_t tbl[6];

  initial begin
    logic [63:0] lp16;
    logic [15:0] lp4;
    tbl[0] = '{2'd0, 16'hFFFE, 0, 3, 16'h0001};
    tbl[1] = '{2'd1, 16'h0001, 1, 3, 16'hFFFE};
    tbl[2] = '{2'd3, 16'h0000, 0, 4, 16'h0010};
    tbl[3] = '{2'd3, 16'h8000, 3, 2, 16'h0002};
    tbl[4] = '{2'd2, 16'h0000, 0, 2, 16'h0004};
    tbl[5] = '{2'd0, 16'h1234, 5, 1, 16'h1235};
    model_reset();

    // clock/reset
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_data", probe_data, 64'h0);
    chk("rst_valid", probe_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_state", dbg_state, 2'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    cfg_write(1, 2'd2, 16'h0000);
    cfg_write(2, 2'd3, 16'h0008);
    cfg_write(3, 2'd1, 16'h0005);

    for (int t = 0; t < 6; t++) begin
      cfg_write(0, tbl[t].mode, tbl[t].seed);
      do_run(tbl[t].r, tbl[t].n, -1, -1, -1);
      chk("tbl_ch0_last", probe_data[15:0], tbl[t].exp_last);
    end

    // 4-bit LFSR (zero seed -> 1) and walking-one from 0x8
    do_run(0, 2, -1, -1, -1);
    chk("lfsr4_after2", probe_data4[7:4], 4'h4);
    chk("walk4_after2", probe_data4[11:8], 4'h2);
    do_run(0, 3, -1, -1, -1);
    chk("lfsr4_after3", probe_data4[7:4], 4'h9);

    // continuous runs ended by stop, with and without a coinciding step
    do_run(2, 0, -1, 9, -1);
    do_run(2, 0, -1, 8, -1);

    // start+stop together in IDLE
    @(negedge clk); start = 1'b1; stop = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    chk("startstop_busy", busy, 1'b0);
    @(negedge clk);
    chk("startstop_done", done, 1'b0);

    // start during RUN must not reload; cfg writes during RUN or to ch>=NUM_CH ignored
    do_run(0, 4, 2, -1, -1);
    do_run(1, 3, -1, -1, 2);
    cfg_write(4, 2'd3, 16'hBEEF);
    do_run(0, 2, -1, -1, -1);

    // reset mid-run
    model_run(2, lp16, lp4);
    @(negedge clk); rate = 8'd1; burst_len = 16'd0; start = 1'b1;
    for (int idx = 0; idx <= 4; idx++) begin
      @(negedge clk); start = 1'b0;
    end
    #2 rst = 1'b0;
    #1;
    chk("midrst_data", probe_data, 64'h0);
    chk("midrst_data4", probe_data4, 16'h0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_valid", probe_valid, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_q", exp_q.size(), 0);
    model_reset();
    repeat (3) @(negedge clk);

    // reset release: first start accepted on the second edge
    model_run(2, lp16, lp4);
    rst = 1'b1; rate = 8'd0; burst_len = 16'd2; start = 1'b1;
    done_exp++;
    @(negedge clk);
    chk("start_edge1_ignored", busy, 1'b0);
    @(negedge clk);
    start = 1'b0;
    chk("start_edge2_accepted", busy, 1'b1);
    repeat (5) @(negedge clk);
    chk("post_rst_data", probe_data, pack16());
    chk("post_rst_q", exp_q.size(), 0);
    chk("post_rst_busy", busy, 1'b0);

    chk("done_total", done_seen, done_exp);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
